// File: rtl/ula_cmd_sequencer.sv
// ula_cmd_sequencer
//   Command front-end for the ula ALU. Operation requests are buffered in a
//   small FIFO, issued to the ALU one at a time, and the ALU result is returned
//   with a sequence tag on a valid/ready response port. After each response the
//   ALU is parked on op 0 so that its sticky valid clears before the next issue.
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   i_cmd_valid / o_cmd_ready        command push handshake (ready = FIFO not full)
//   i_cmd_op, i_cmd_a, i_cmd_b       command payload (legal ops 1..8)
//   o_op_selector, o_data_a/b        ALU inputs
//   i_ula_valid/result/carry         ALU outputs
//   o_rsp_valid / i_rsp_ready        response handshake
//   o_rsp_result/carry/op/tag/err    response payload
//   o_fifo_count                     FIFO occupancy
module ula_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [4:0]             i_cmd_op,
  input  logic [15:0]            i_cmd_a,
  input  logic [15:0]            i_cmd_b,
  output logic [4:0]             o_op_selector,
  output logic [15:0]            o_data_a,
  output logic [15:0]            o_data_b,
  input  logic                   i_ula_valid,
  input  logic [31:0]            i_ula_result,
  input  logic                   i_ula_carry,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [31:0]            o_rsp_result,
  output logic                   o_rsp_carry,
  output logic [4:0]             o_rsp_op,
  output logic [7:0]             o_rsp_tag,
  output logic                   o_rsp_err,
  output logic [$clog2(DEPTH):0] o_fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_CLEAR
  } state_t;

  state_t state, state_nxt;

  logic [4:0]    mem_op  [DEPTH];
  logic [15:0]   mem_a   [DEPTH];
  logic [15:0]   mem_b   [DEPTH];
  logic [7:0]    mem_tag [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    tag_cnt;
  logic          rst_done;
  logic          full, empty, push, pop;
  logic [4:0]    head_op;
  logic          head_legal;

  logic [4:0]    w_op;
  logic [15:0]   w_a, w_b;
  logic [7:0]    w_tag;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;
  logic [31:0]   rsp_result;
  logic          rsp_carry, rsp_err;
  logic          drive_alu;

  // rst_done keeps ready low while reset is held and raises it on the first
  // clock after release.
  assign full        = (count == (AW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign o_cmd_ready = rst_done && !full;
  assign push        = i_cmd_valid && o_cmd_ready;
  assign head_op     = mem_op[rd_ptr];
  assign head_legal  = (head_op != 5'd0) && (head_op <= 5'd8);
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr]  <= i_cmd_op;
      mem_a[wr_ptr]   <= i_cmd_a;
      mem_b[wr_ptr]   <= i_cmd_b;
      mem_tag[wr_ptr] <= tag_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tag_cnt  <= '0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        tag_cnt <= tag_cnt + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          // Illegal ops never reach the ALU; they answer with an error directly.
          state_nxt = head_legal ? S_ISSUE : S_RESP;
        end
      end
      // The ALU valid may be stale while the new op is being sampled.
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (i_ula_valid || timeout_hit) state_nxt = S_RESP;
      S_RESP:  if (i_rsp_ready) state_nxt = S_CLEAR;
      S_CLEAR: if (!i_ula_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_op       <= '0;
      w_a        <= '0;
      w_b        <= '0;
      w_tag      <= '0;
      wait_cnt   <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (pop) begin
        w_op       <= head_op;
        w_a        <= mem_a[rd_ptr];
        w_b        <= mem_b[rd_ptr];
        w_tag      <= mem_tag[rd_ptr];
        rsp_result <= '0;
        rsp_carry  <= 1'b0;
        rsp_err    <= !head_legal;
      end
      if (state == S_ISSUE)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + CW'(1);
      if (state == S_WAIT) begin
        if (i_ula_valid) begin
          rsp_result <= i_ula_result;
          rsp_carry  <= i_ula_carry;
          rsp_err    <= 1'b0;
        end else if (timeout_hit) begin
          rsp_result <= '0;
          rsp_carry  <= 1'b0;
          rsp_err    <= 1'b1;
        end
      end
    end
  end

  assign drive_alu     = (state == S_ISSUE) || (state == S_WAIT);
  assign o_op_selector = drive_alu ? w_op : '0;
  assign o_data_a      = drive_alu ? w_a  : '0;
  assign o_data_b      = drive_alu ? w_b  : '0;

  assign o_rsp_valid   = (state == S_RESP);
  assign o_rsp_result  = rsp_result;
  assign o_rsp_carry   = rsp_carry;
  assign o_rsp_op      = w_op;
  assign o_rsp_tag     = w_tag;
  assign o_rsp_err     = rsp_err;
  assign o_fifo_count  = count;

endmodule

// File: tb/tb_ula_cmd_sequencer.sv
// Self-checking bench for ula_cmd_sequencer with a behavioural ula model.
module tb_ula_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [4:0]  i_cmd_op = '0;
  logic [15:0] i_cmd_a = '0;
  logic [15:0] i_cmd_b = '0;
  logic [4:0]  o_op_selector;
  logic [15:0] o_data_a, o_data_b;
  logic        i_ula_valid;
  logic [31:0] i_ula_result;
  logic        i_ula_carry;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_result;
  logic        o_rsp_carry;
  logic [4:0]  o_rsp_op;
  logic [7:0]  o_rsp_tag;
  logic        o_rsp_err;
  logic [$clog2(DEPTH):0] o_fifo_count;

  // ALU model and valid overrides
  logic        alu_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic        alu_carry = 1'b0;
  logic        tie0 = 1'b0;
  logic        tie1 = 1'b0;
  logic        alu_touched = 1'b0;

  assign i_ula_valid  = tie0 ? 1'b0 : (tie1 ? 1'b1 : alu_valid);
  assign i_ula_result = alu_result;
  assign i_ula_carry  = alu_carry;

  typedef struct packed {
    logic [4:0]  op;
    logic [7:0]  tag;
    logic        err;
    logic [31:0] result;
    logic        carry;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          rsp_seen = 0;
  logic [7:0]  tb_tag = '0;

  ula_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
    .o_op_selector(o_op_selector), .o_data_a(o_data_a), .o_data_b(o_data_b),
    .i_ula_valid(i_ula_valid), .i_ula_result(i_ula_result), .i_ula_carry(i_ula_carry),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_result(o_rsp_result), .o_rsp_carry(o_rsp_carry), .o_rsp_op(o_rsp_op),
    .o_rsp_tag(o_rsp_tag), .o_rsp_err(o_rsp_err), .o_fifo_count(o_fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_f(input logic [4:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    alu_f = '0;
    r = '0;
    case (op)
      5'd1: begin s = {1'b0, a} + {1'b0, b}; alu_f = {s[16], 16'h0, s[15:0]}; end
      5'd2: begin s = {1'b0, a} - {1'b0, b}; alu_f = {s[16], 16'h0, s[15:0]}; end
      5'd3: alu_f = {1'b0, 32'(a) * 32'(b)};
      5'd4: alu_f = (b == 16'h0) ? '0 : {17'h0, a / b};
      5'd5: alu_f = {17'h0, a & b};
      5'd6: alu_f = {17'h0, a | b};
      5'd7: alu_f = {17'h0, a ^ b};
      5'd8: begin
        for (int i = 0; i < 16; i++) r[i] = a[15-i];
        alu_f = {17'h0, r};
      end
      default: alu_f = '0;
    endcase
  endfunction

  // Registered ALU: valid is sticky until op 0 is presented.
  always @(posedge clk) begin
    if (o_op_selector >= 5'd1 && o_op_selector <= 5'd8) begin
      alu_valid <= 1'b1;
      {alu_carry, alu_result} <= alu_f(o_op_selector, o_data_a, o_data_b);
    end else if (o_op_selector == 5'd0) begin
      alu_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (o_op_selector != 5'd0 || o_data_a != 16'h0 || o_data_b != 16'h0) alu_touched = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Response monitor: handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && o_rsp_valid && i_rsp_ready) begin
      rsp_seen++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected: got response tag %0d expected none", o_rsp_tag);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("rsp_result", o_rsp_result, mon_e.result);
        check("rsp_carry", 32'(o_rsp_carry), 32'(mon_e.carry));
        check("rsp_op", 32'(o_rsp_op), 32'(mon_e.op));
        check("rsp_tag", 32'(o_rsp_tag), 32'(mon_e.tag));
        check("rsp_err", 32'(o_rsp_err), 32'(mon_e.err));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push_cmd(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input bit expect_rsp);
    logic [32:0] r;
    exp_t        e;
    bit          done;
    done        = 1'b0;
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_a     = a;
    i_cmd_b     = b;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (o_cmd_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    i_cmd_valid = 1'b0;
    check("push_accepted", 32'(done), 32'd1);
    if (done) begin
      if (expect_rsp) begin
        r        = alu_f(op, a, b);
        e.op     = op;
        e.tag    = tb_tag;
        e.err    = (op == 5'd0) || (op > 5'd8) || tie0;
        e.result = e.err ? 32'h0 : r[31:0];
        e.carry  = e.err ? 1'b0 : r[32];
        sb.push_back(e);
      end
      tb_tag++;
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !o_rsp_valid) ok = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain", 32'(ok), 32'd1);
  endtask

  // Returns cycles from the current point until o_rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (o_rsp_valid) lat = n;
    end
  endtask

  initial begin
    int lat;
    int saved;
    bit seen;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(o_cmd_ready), 32'd0);
    check("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("reset_op_sel", 32'(o_op_selector), 32'd0);
    check("reset_count", 32'(o_fifo_count), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(o_cmd_ready), 32'd1);

    // ADD latency
    i_rsp_ready = 1'b1;
    push_cmd(5'd1, 16'h0003, 16'h0004, 1'b1);
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        check("issue_op", 32'(o_op_selector), 32'd1);
        check("issue_a", 32'(o_data_a), 32'h3);
      end
      if (o_rsp_valid) lat = n;
    end
    check("add_latency", lat, 32'd3);
    check("add_result", o_rsp_result, 32'h7);
    check("resp_op_sel_zero", 32'(o_op_selector), 32'd0);
    wait_drain();

    // Backpressure: five pushes, one popped, FIFO full
    i_rsp_ready = 1'b0;
    push_cmd(5'd2, 16'h0005, 16'h0009, 1'b1);
    push_cmd(5'd3, 16'h1234, 16'h0100, 1'b1);
    push_cmd(5'd4, 16'd100, 16'd7, 1'b1);
    push_cmd(5'd6, 16'hA000, 16'h000A, 1'b1);
    push_cmd(5'd8, 16'h0001, 16'h0000, 1'b1);
    check("full_count", 32'(o_fifo_count), 32'd4);
    check("full_ready", 32'(o_cmd_ready), 32'd0);
    i_cmd_valid = 1'b1;
    i_cmd_op    = 5'd1;
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
    check("full_refuse_count", 32'(o_fifo_count), 32'd4);
    i_rsp_ready = 1'b1;
    wait_drain();

    // Illegal ops never drive the ALU
    alu_touched = 1'b0;
    push_cmd(5'd0, 16'h0005, 16'h0006, 1'b1);
    push_cmd(5'd9, 16'h0007, 16'h0008, 1'b1);
    wait_drain();
    check("illegal_alu_untouched", 32'(alu_touched), 32'd0);

    // Timeout, then recovery
    tie0 = 1'b1;
    push_cmd(5'd2, 16'd10, 16'd3, 1'b1);
    wait_rsp(lat);
    check("timeout_latency", lat, 32'(TIMEOUT + 2));
    wait_drain();
    tie0 = 1'b0;
    push_cmd(5'd6, 16'h00F0, 16'h0F00, 1'b1);
    wait_drain();

    // CLEAR holds while the ALU valid stays high
    i_rsp_ready = 1'b0;
    push_cmd(5'd5, 16'hF0F0, 16'hFF00, 1'b1);
    push_cmd(5'd7, 16'h1234, 16'h00FF, 1'b1);
    wait_rsp(lat);
    check("hold_first_rsp", 32'(o_rsp_valid), 32'd1);
    tie1        = 1'b1;
    i_rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      check("clear_hold_op", 32'(o_op_selector), 32'd0);
      check("clear_hold_rsp", 32'(o_rsp_valid), 32'd0);
    end
    tie1 = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (o_op_selector == 5'd7) seen = 1'b1;
    end
    check("queued_issued", 32'(seen), 32'd1);
    wait_drain();

    // Reset during WAIT with two queued commands
    tie0 = 1'b1;
    push_cmd(5'd2, 16'h0001, 16'h0001, 1'b0);
    push_cmd(5'd1, 16'h0002, 16'h0002, 1'b0);
    push_cmd(5'd1, 16'h0003, 16'h0003, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_count", 32'(o_fifo_count), 32'd2);
    check("pre_reset_op", 32'(o_op_selector), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_op", 32'(o_op_selector), 32'd0);
    check("midreset_count", 32'(o_fifo_count), 32'd0);
    check("midreset_ready", 32'(o_cmd_ready), 32'd0);
    check("midreset_rsp", 32'(o_rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    tie0   = 1'b0;
    tb_tag = '0;
    saved  = rsp_seen;
    repeat (20) @(posedge clk);
    #1;
    check("no_rsp_after_reset", rsp_seen, saved);
    push_cmd(5'd1, 16'h1234, 16'hFFFF, 1'b1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
